// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential HI/LO multiplier.
package mult_pkg;

  localparam int unsigned MULT_WIDTH = 32;
  localparam int unsigned MULT_STEPS = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } mult_state_e;

  // Magnitude of a two's-complement operand when signed; 0x80000000 maps to
  // itself, which is the correct unsigned magnitude.
  function automatic logic [MULT_WIDTH-1:0] neg_abs(
    input logic [MULT_WIDTH-1:0] v,
    input logic                  is_signed
  );
    return (is_signed && v[MULT_WIDTH-1]) ? (~v + MULT_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/mult_step_dp.sv
// Single radix-2 shift-add step: conditional add into the upper accumulator,
// then shift {carry, acc_hi, mplier} right by one.
module mult_step_dp #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_acc_hi,
  input  logic [WIDTH-1:0] i_mplier,
  input  logic [WIDTH-1:0] i_mcand,
  output logic [WIDTH-1:0] o_acc_hi,
  output logic [WIDTH-1:0] o_mplier
);

  logic [WIDTH:0] w_sum;

  // Add multiplicand when the current multiplier LSB is set, keep the carry,
  // and shift the combined register right.
  always_comb begin
    w_sum = {1'b0, i_acc_hi};
    if (i_mplier[0]) begin
      w_sum = w_sum + {1'b0, i_mcand};
    end
    o_acc_hi = w_sum[WIDTH:1];
    o_mplier = {w_sum[0], i_mplier[WIDTH-1:1]};
  end

endmodule

// File: rtl/mult_seq_hilo.sv
// Sequential radix-2 shift-add multiplier producing a HI/LO split product
// for MULT/MULTU. Fixed 32-step latency by default; define
// MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are
// zero.
module mult_seq_hilo
  import mult_pkg::*;
#(
  parameter int unsigned WIDTH = MULT_WIDTH,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  mult_state_e        r_state;
  mult_state_e        w_state_next;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplier;
  logic [WIDTH-1:0]   r_acc;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_neg;
  logic               w_take;
  logic               w_last;
  logic [WIDTH-1:0]   w_acc_next;
  logic [WIDTH-1:0]   w_mplier_next;
  logic [2*WIDTH-1:0] w_prod_raw;
  logic [2*WIDTH-1:0] w_prod;

  mult_step_dp #(.WIDTH(WIDTH)) u_step (
    .i_acc_hi (r_acc),
    .i_mplier (r_mplier),
    .i_mcand  (r_mcand),
    .o_acc_hi (w_acc_next),
    .o_mplier (w_mplier_next)
  );

`ifdef MULT_EARLY_TERM_EN
  logic [CNT_W-1:0] w_k;
  logic [CNT_W-1:0] w_shamt;
  logic [WIDTH-1:0] w_rem_mask;

  // After k steps the low WIDTH-k bits of the multiplier register are still
  // unconsumed; once they are zero the remaining steps only shift, so the
  // final value is the concatenation shifted by the steps left over.
  assign w_k        = r_cnt + CNT_W'(1);
  assign w_shamt    = CNT_W'(WIDTH) - w_k;
  assign w_rem_mask = {WIDTH{1'b1}} >> w_k;
  assign w_last     = (r_cnt == CNT_W'(MULT_STEPS - 1)) ||
                      ((w_mplier_next & w_rem_mask) == '0);
  assign w_prod_raw = {w_acc_next, w_mplier_next} >> w_shamt;
`else
  assign w_last     = (r_cnt == CNT_W'(MULT_STEPS - 1));
  assign w_prod_raw = {w_acc_next, w_mplier_next};
`endif

  assign w_prod = r_neg ? -w_prod_raw : w_prod_raw;
  assign hi     = r_hi;
  assign lo     = r_lo;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state decode and status outputs.
  always_comb begin
    w_state_next = r_state;
    w_take       = 1'b0;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next = RUN;
          w_take       = 1'b1;
        end
      end
      RUN: begin
        busy = 1'b1;
        if (w_last) w_state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_state_next = RUN;
          w_take       = 1'b1;
        end else begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Operand capture, per-step accumulation and result load on completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else if (w_take) begin
      r_mcand  <= neg_abs(a, is_signed);
      r_mplier <= neg_abs(b, is_signed);
      r_acc    <= '0;
      r_cnt    <= '0;
      r_neg    <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (r_state == RUN) begin
      r_acc    <= w_acc_next;
      r_mplier <= w_mplier_next;
      r_cnt    <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_hi <= w_prod[2*WIDTH-1:WIDTH];
        r_lo <= w_prod[WIDTH-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mult_seq_hilo.sv
// Scoreboard bench for mult_seq_hilo: stimulus pushes expected results,
// a negedge monitor pops and checks them whenever done is presented.
module tb_mult_seq_hilo;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

`ifdef MULT_EARLY_TERM_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  mult_seq_hilo #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_signed (is_signed),
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          dcyc;
    string       name;
  } exp_t;

  exp_t sb[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_done  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Number of add-shift steps before done: 32 normally, or up to the highest
  // set bit of |b| (minimum one) with early termination.
  function automatic int exp_steps(input logic [31:0] bv, input logic s);
    logic [31:0] m;
    int n;
    m = (s && bv[31]) ? (~bv + 32'd1) : bv;
    n = 1;
    for (int i = 0; i < 32; i++) if (m[i]) n = i + 1;
    return EARLY ? n : 32;
  endfunction

  task automatic push_exp(input string name, input logic [31:0] bv, input logic s,
                          input logic [31:0] ehi, input logic [31:0] elo);
    sb.push_back('{hi: ehi, lo: elo, dcyc: cyc + 1 + exp_steps(bv, s), name: name});
  endtask

  task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic s);
    start     = 1'b1;
    a         = av;
    b         = bv;
    is_signed = s;
    @(negedge clk);
    start     = 1'b0;
    a         = $urandom;
    b         = $urandom;
    is_signed = 1'b1;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    while (!done && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL %s_timeout: no done within 40 cycles, expected a done pulse", name);
    end
  endtask

  task automatic run_op(input string name, input logic [31:0] av, input logic [31:0] bv,
                        input logic s, input logic [31:0] ehi, input logic [31:0] elo);
    push_exp(name, bv, s, ehi, elo);
    issue(av, bv, s);
    wait_done(name);
    @(negedge clk);
  endtask

  // Monitor: every done pulse must match the oldest outstanding request.
  always @(negedge clk) begin
    exp_t e;
    if (!reset && done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_done: done at cycle %0d, expected no done", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_hi"}, 64'(hi), 64'(e.hi));
        chk({e.name, "_lo"}, 64'(lo), 64'(e.lo));
        chk({e.name, "_cycle"}, 64'(cyc), 64'(e.dcyc));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nd;
    reset     = 1'b1;
    start     = 1'b0;
    is_signed = 1'b0;
    a         = '0;
    b         = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi",   64'(hi),   64'd0);
    chk("rst_lo",   64'(lo),   64'd0);
    reset = 1'b0;
    @(negedge clk);

    // MULTU max * max with busy window and single-cycle done.
    push_exp("t1_multu_max", 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 32'h0000_0001);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    for (int k = 0; k < 32; k++) begin
      chk("t1_busy_high", 64'(busy), 64'd1);
      @(negedge clk);
    end
    chk("t1_busy_low_at_done", 64'(busy), 64'd0);
    chk("t1_done_high",        64'(done), 64'd1);
    @(negedge clk);
    chk("t1_done_one_cycle",   64'(done), 64'd0);

    // Signed cases.
    run_op("t2_mult_m3x5",   32'hFFFF_FFFD, 32'd5,         1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("t3_mult_minmin", 32'h8000_0000, 32'h8000_0000, 1'b1, 32'h4000_0000, 32'h0000_0000);

    // Start during RUN is ignored.
    push_exp("t4_ignored_start", 32'd3, 1'b0, 32'd0, 32'd6);
    issue(32'd2, 32'd3, 1'b0);
    start = 1'b1;
    a     = 32'd7;
    b     = 32'd9;
    @(negedge clk);
    start = 1'b0;
    wait_done("t4_ignored_start");
    @(negedge clk);
    nd = n_done;
    repeat (40) @(negedge clk);
    chk("t4_no_extra_done", 64'(n_done), 64'(nd));

    // Back-to-back: start held through DONE; old result held until new done.
    push_exp("t5a_first", 32'h10, 1'b0, 32'h0000_0001, 32'h2345_6780);
    issue(32'h1234_5678, 32'h10, 1'b0);
    wait_done("t5a_first");
    push_exp("t5b_b2b", 32'd10, 1'b0, 32'd0, 32'd100);
    issue(32'd10, 32'd10, 1'b0);
    begin
      int k;
      k = 0;
      while (!done && k < 40) begin
        chk("t5_hold_hi", 64'(hi), 64'h0000_0001);
        chk("t5_hold_lo", 64'(lo), 64'h2345_6780);
        @(negedge clk);
        k++;
      end
    end
    wait_done("t5b_b2b");
    @(negedge clk);

    // Reset in the middle of RUN: cleared outputs and no done afterwards.
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (9) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", 64'(busy), 64'd0);
    chk("t6_rst_done", 64'(done), 64'd0);
    chk("t6_rst_hi",   64'(hi),   64'd0);
    chk("t6_rst_lo",   64'(lo),   64'd0);
    reset = 1'b0;
    nd = n_done;
    repeat (40) @(negedge clk);
    chk("t6_no_done_after_rst", 64'(n_done), 64'(nd));

    // Short multipliers (early-termination boundaries when enabled).
    run_op("t7_b_zero",    32'hDEAD_BEEF, 32'd0,         1'b0, 32'd0,         32'd0);
    run_op("t8_b_one",     32'h1234_5678, 32'd1,         1'b0, 32'd0,         32'h1234_5678);
    run_op("t9_b_neg_one", 32'h1234_5678, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 32'hEDCB_A988);

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
